// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and GF(2^8) helpers.
//   aes_block_t       128-bit block, byte 0 at [127:120]
//   AES256_ROUNDS     cipher rounds after the initial AddRoundKey
//   AES_KEY_CHAIN_W   width of the 15-entry round-key chain
//   aes_iter_state_e  FSM encoding shared by the iterative cores
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    localparam int AES256_ROUNDS   = 14;
    localparam int AES_KEY_CHAIN_W = (AES256_ROUNDS + 1) * 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_iter_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed algebraically: x^254 is the multiplicative inverse
    // (0 maps to 0), followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] y;
        sq = x;
        y  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            y  = gf_mul(y, sq);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/add_round_key.sv
// add_round_key: XOR of block and round key.
//   in_i  : block in
//   key_i : round key
//   out_o : in_i ^ key_i
module add_round_key (
    input  logic [127:0] in_i,
    input  logic [127:0] key_i,
    output logic [127:0] out_o
);
    assign out_o = in_i ^ key_i;
endmodule

// File: rtl/aes_encryption_round.sv
// aes_encryption_round: one combinational AES encryption round.
//   in_i    : state before the round
//   key_i   : round key
//   final_i : last round, MixColumns bypassed
//   out_o   : state after the round
module aes_encryption_round
    import aes_pkg::*;
(
    input  aes_block_t in_i,
    input  aes_block_t key_i,
    input  logic       final_i,
    output aes_block_t out_o
);
    aes_block_t sb, sr, mc;

    sub_bytes     u_sb  (.in_i(in_i), .out_o(sb));
    shift_rows    u_sr  (.in_i(sb),   .out_o(sr));
    mix_columns   u_mc  (.in_i(sr),   .out_o(mc));
    add_round_key u_ark (.in_i(final_i ? sr : mc), .key_i(key_i), .out_o(out_o));
endmodule

// File: rtl/mix_columns.sv
// mix_columns: multiplies each column by the fixed {02,03,01,01} circulant.
//   in_i  : block in
//   out_o : mixed block
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] in_i,
    output logic [127:0] out_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = in_i[127-32*c -: 32];
        assign out_o[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end
endmodule

// File: rtl/shift_rows.sv
// shift_rows: cyclic left shift of row r by r bytes. Bytes are column
// major: byte 4*c+r is row r of column c.
//   in_i  : block in
//   out_o : shifted block
module shift_rows (
    input  logic [127:0] in_i,
    output logic [127:0] out_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c + r) % 4) + r;
            assign out_o[127-8*(4*c+r) -: 8] = in_i[127-8*SRC -: 8];
        end
    end
endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: applies the AES S-box to all 16 bytes.
//   in_i  : block in
//   out_o : substituted block
module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] in_i,
    output logic [127:0] out_o
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign out_o[8*i +: 8] = sbox(in_i[8*i +: 8]);
    end
endmodule

// File: rtl/aes_encryption_iter.sv
// aes_encryption_iter: iterative AES-256 encryption, one round per clock.
//   clk_i, reset_ni : clock, async active-low reset
//   plaintext_i     : input block, sampled on accept (v_i & ready_o)
//   key_chain_i     : 15 round keys, key r at [r*128 +: 128]
//   v_i / ready_o   : input handshake
//   ciphertext_o    : result, valid while v_o
//   v_o / yumi_i    : output handshake
// Optional feature macro: AES_ENC_KEY_CAPTURE_EN -- registers the whole key
// chain on accept so the source may change it while the block is in flight.
module aes_encryption_iter
    import aes_pkg::*;
#(
    parameter int rounds_p = AES256_ROUNDS
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  aes_block_t                 plaintext_i,
    input  logic [AES_KEY_CHAIN_W-1:0] key_chain_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output aes_block_t                 ciphertext_o,
    output logic                       v_o,
    input  logic                       yumi_i
);
    aes_iter_state_e st_q;
    logic [3:0]      rnd_q;
    aes_block_t      blk_q;
    aes_block_t      round_out;
    logic            last_rnd;

    logic [AES256_ROUNDS:0][127:0] keys_in;
    logic [AES256_ROUNDS:0][127:0] keys_run;

    assign keys_in = key_chain_i;

`ifdef AES_ENC_KEY_CAPTURE_EN
    logic [AES_KEY_CHAIN_W-1:0] kc_q;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)                          kc_q <= '0;
        else if (st_q == IDLE && v_i)           kc_q <= key_chain_i;
    end
    assign keys_run = kc_q;
`else
    // Caller keeps key_chain_i stable for the whole block.
    assign keys_run = key_chain_i;
`endif

    assign last_rnd = (rnd_q == 4'(rounds_p));

    aes_encryption_round u_round (
        .in_i   (blk_q),
        .key_i  (keys_run[rnd_q]),
        .final_i(last_rnd),
        .out_o  (round_out)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            st_q  <= IDLE;
            rnd_q <= '0;
            blk_q <= '0;
        end else begin
            case (st_q)
                IDLE: if (v_i) begin
                    // Initial AddRoundKey folded into the accept edge.
                    blk_q <= plaintext_i ^ keys_in[0];
                    rnd_q <= 4'd1;
                    st_q  <= RUN;
                end
                RUN: begin
                    blk_q <= round_out;
                    if (last_rnd) begin
                        rnd_q <= '0;
                        st_q  <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: if (yumi_i) st_q <= IDLE;
                default: st_q <= IDLE;
            endcase
        end
    end

    assign ready_o      = (st_q == IDLE);
    assign v_o          = (st_q == DONE);
    assign ciphertext_o = blk_q;

    // Consumer may only take a result that is being offered.
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_ni)
        yumi_i |-> (st_q == DONE));
endmodule

// File: doc/aes_encryption_iter.md
# aes_encryption_iter

Iterative AES-256 encryption core: one round per clock, reusing a single round datapath over the 15-entry round-key chain produced by the existing key expansion. It is the transmit-side counterpart of the pipelined decryption path and consumes the same key-chain layout, so both directions share one key schedule. A valid/ready input handshake and a valid/yumi output handshake let it sit between a plaintext source FIFO and a ciphertext sink.

## Interface
Parameters
- `rounds_p`, default 14: number of cipher rounds after the initial AddRoundKey. Only 14 (AES-256) is supported.

Ports
- `clk_i`  in  1  clock
- `reset_ni`  in  1  asynchronous, active-low reset
- `plaintext_i`  in  128  input block; byte 0 at [127:120]
- `key_chain_i`  in  1920  round keys; key r at [r*128 +: 128], r = 0..14
- `v_i`  in  1  plaintext_i valid
- `ready_o`  out  1  core can accept a block
- `ciphertext_o`  out  128  result block; same byte order
- `v_o`  out  1  ciphertext_o valid
- `yumi_i`  in  1  consumer takes ciphertext_o; legal only while v_o = 1

## Operation
- FSM states:
  - IDLE: `ready_o` = 1, `v_o` = 0.
  - RUN: `ready_o` = 0, `v_o` = 0, round counter `rnd` = 1..14.
  - DONE: `ready_o` = 0, `v_o` = 1.
- IDLE, when `v_i & ready_o`:
  - state register <= `plaintext_i ^ key0`
  - `rnd` <= 1
  - go to RUN
- RUN, each cycle: state <= round(state, key[rnd]).
  - Rounds 1..13 apply SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 14 skips MixColumns.
  - `rnd` increments. After round 14, go to DONE and `rnd` <= 0.
- DONE: `ciphertext_o` is held stable. On `yumi_i`, go to IDLE.
- `v_i` is ignored outside IDLE. `plaintext_i` is sampled only on the accept edge.
- `yumi_i` is ignored outside DONE. Asserting it there is a protocol error, flagged by an assertion and otherwise ignored.
- `ciphertext_o` is driven from the state register. Its value is meaningful only while `v_o` = 1.
- Reset (asynchronous, any state, including mid-RUN):
  - FSM goes to IDLE, `rnd` = 0, state register = 0.
  - The in-flight block is discarded.
- Reset values of outputs: `ready_o` = 1, `v_o` = 0, `ciphertext_o` = 0.

## Timing
- Accept at edge E0. Rounds occur at E1..E14. `v_o` rises after E14, so accept-to-valid latency is 14 cycles.
- `yumi_i` high in the first DONE cycle returns the FSM to IDLE at E15. The next accept can happen at E16.
- Minimum spacing is 16 cycles per block.
- `ready_o` and `v_o` are decoded from registered state only. There is no combinational path from any input to any output.
- `key_chain_i` requirements depend on the configuration below.
- Critical path is one round: S-box, MixColumns and XOR, plus a 15:1 key mux.

## Configuration
- Macro: `AES_ENC_KEY_CAPTURE_EN`.
- Defined:
  - All 1920 bits of `key_chain_i` are registered on the accept edge, and rounds use the captured copy.
  - The key chain may change as soon as the block is accepted.
  - The capture register resets to 0.
- Undefined:
  - No capture register.
  - `key_chain_i` must stay stable from the accept edge until `v_o` rises. Changing it earlier corrupts the result; no detection is provided.
- Latency and throughput are identical in both configurations.

## Structure
- Shared package `aes_pkg`:
  - `aes_block_t` (`logic [127:0]`)
  - `AES256_ROUNDS` = 14
  - `AES_KEY_CHAIN_W` = 1920
  - FSM enum `aes_iter_state_e` {IDLE, RUN, DONE}, reused by a later iterative decryption core.
- One sub-module, `aes_encryption_round`:
  - Combinational: in, key, `final_i` → out.
  - `final_i` bypasses MixColumns.
  - Built from the existing `sub_bytes`, `shift_rows`, `mix_columns` and `add_round_key` modules.
- The top module holds the FSM, round counter, state register, key mux, and the optional key capture register.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102…1f expanded into `key_chain_i`.
  - Expected: `v_o` rises exactly 14 cycles after accept; `ciphertext_o` = 8ea2b7ca516745bfeafc49904b496089.
- Output back-pressure:
  - Stimulus: hold `yumi_i` = 0 for 20 cycles.
  - Expected: `v_o` and `ciphertext_o` stay stable; `ready_o` = 0; a `v_i` pulse during this time is not accepted.
- Back-to-back blocks:
  - Stimulus: `v_i` held high with two blocks; `yumi_i` asserted as soon as `v_o` rises.
  - Expected: accepts at cycles 0 and 16; both ciphertexts correct.
- Reset mid-operation:
  - Stimulus: pull `reset_ni` low at round 7.
  - Expected: `v_o` = 0, `ready_o` = 1, `ciphertext_o` = 0 immediately. A new C.3 block issued after release completes correctly.
- Key capture, with `AES_ENC_KEY_CAPTURE_EN`:
  - Stimulus: overwrite `key_chain_i` with all-ones one cycle after accept.
  - Expected: output is still 8ea2b7ca516745bfeafc49904b496089.
  - Same test without the macro: output differs from the C.3 ciphertext.
- Round trip:
  - Stimulus: 100 random keys and blocks encrypted, then fed through the decryption pipeline.
  - Expected: every block recovers its original plaintext.
